noise_injector: RTL and testbench
=================================

// Module: noise_injector
// PURPOSE
//  Test-signal stage sitting directly upstream of the moving-average filter.
//  Adds pseudo-random noise to each left-channel sample read from the audio CODEC.
//  The filter then removes that noise, so smoothing can be heard and checked.
//  Noise comes from a 16-bit LFSR; the sum saturates to 24-bit signed; output is registered.
// PARAMETERS
//  DATA_W       24        sample width, two's complement
//  NOISE_SHIFT  4         left shift applied to the sign-extended LFSR word (sets noise amplitude)
//  SEED         16'hACE1  LFSR reset value; SEED==0 is replaced by 16'h0001
// PORTS
//  clk        in   1       system clock (50 MHz domain)
//  reset_n    in   1       asynchronous, active-low reset
//  enable     in   1       one-cycle sample strobe (CODEC read & write ready)
//  noise_on   in   1       1 = add noise, 0 = pass data_in unmodified
//  data_in    in   DATA_W  signed input sample
//  data_out   out  DATA_W  signed noisy sample, registered
//  out_valid  out  1       1-cycle pulse; data_out was updated on this edge
//  clip_count out  16      number of saturated samples since reset
// BEHAVIOUR
//  Reset (reset_n=0, async, also mid-operation):
//   - lfsr = SEED, or 16'h0001 if SEED==0
//   - data_out = 0, out_valid = 0, clip_count = 0
//   - takes effect immediately, with no dependence on clk
//  LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
//   - fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]
//   - next = {lfsr[14:0], fb}
//   - advances only on clk edges with enable=1, regardless of noise_on
//   - all-zero state is unreachable
//  Noise word for a sample:
//   - taken from the current lfsr value, before the advance on that edge
//   - noise = sign_extend(lfsr, DATA_W) <<< NOISE_SHIFT, truncated to DATA_W
//  On a clk edge with enable=1:
//   - sum = sext(data_in, DATA_W+1) + (noise_on ? sext(noise, DATA_W+1) : 0)
//   - sum > 2^(DATA_W-1)-1 -> data_out = 0x7FFFFF, clip_count += 1
//   - sum < -2^(DATA_W-1) -> data_out = 0x800000, clip_count += 1
//   - otherwise data_out = sum[DATA_W-1:0]
//   - clip_count saturates at 16'hFFFF and does not wrap
//   - out_valid = 1 on the same edge
//  On a clk edge with enable=0:
//   - lfsr, data_out and clip_count hold
//   - out_valid = 0
//  Latency: data_out/out_valid are valid exactly 1 clk after the enable edge.
//  Throughput: enable may be high every cycle; each cycle is one independent sample.
//  noise_on is sampled on the enable edge only.
//   - toggling it does not perturb the LFSR sequence
//   - with noise_on=0, data_out == data_in and no clipping is possible
//  The block is purely synchronous apart from reset: no combinational path from inputs to outputs.
// TESTING
//  1. Reset with SEED default; enable=1, noise_on=1, data_in=0
//     -> data_out=24'hFACE10, out_valid=1 for 1 cycle, lfsr=16'h59C3 afterwards.
//  2. After test 1, enable with data_in=24'h7FFFF0 (noise 0x059C30)
//     -> data_out=24'h7FFFFF, clip_count=1.
//     Then from reset: data_in=24'h800000 with first noise -> data_out=24'h800000, clip_count=1.
//  3. noise_on=0, enable every cycle, data_in ramp 0..15
//     -> data_out equals the ramp delayed 1 clk.
//     After 16 samples lfsr matches the reference model's 16th state.
//  4. enable held low 20 cycles with changing data_in
//     -> data_out, lfsr and clip_count unchanged; out_valid=0 throughout.
//  5. Assert reset_n=0 between clk edges mid-stream
//     -> outputs clear immediately; first post-reset sample reproduces test 1 exactly.
//  6. Force 70000 clipping samples
//     -> clip_count sticks at 16'hFFFF.
//     Random data_in for 10k samples against the behavioural model -> zero mismatches.

Source files
------------

// File: rtl/noise_injector.sv
// Adds LFSR-derived noise to each strobed audio sample, saturating to DATA_W signed.
// One register stage between the enable edge and data_out/out_valid.
module noise_injector #(
    parameter int          DATA_W      = 24,
    parameter int          NOISE_SHIFT = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     noise_on,
    input  logic signed [DATA_W-1:0] data_in,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     out_valid,
    output logic [15:0]              clip_count
);

    // An all-zero seed would lock the LFSR, so it is remapped.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic sat_overflow(input logic signed [DATA_W:0] s);
        return s[DATA_W] != s[DATA_W-1];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_value(input logic signed [DATA_W:0] s);
        if (sat_overflow(s))
            return s[DATA_W] ? SAT_MIN : SAT_MAX;
        return s[DATA_W-1:0];
    endfunction

    logic [15:0]              r_lfsr;
    logic signed [DATA_W-1:0] r_data_p1;
    logic                     r_vld_p1;
    logic [15:0]              r_clip_cnt;

    logic                     w_fb;
    logic signed [DATA_W-1:0] w_lfsr_sext;
    logic signed [DATA_W-1:0] w_noise;
    logic signed [DATA_W:0]   w_din_ext;
    logic signed [DATA_W:0]   w_noise_ext;
    logic signed [DATA_W:0]   w_sum_p0;
    logic                     w_clip_p0;

    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_sext = {{(DATA_W-16){r_lfsr[15]}}, r_lfsr};
    assign w_noise     = w_lfsr_sext <<< NOISE_SHIFT;
    assign w_din_ext   = {data_in[DATA_W-1], data_in};
    assign w_noise_ext = noise_on ? {w_noise[DATA_W-1], w_noise} : '0;
    assign w_sum_p0    = w_din_ext + w_noise_ext;
    assign w_clip_p0   = sat_overflow(w_sum_p0);

    // p0 -> p1: register the saturated sum, valid pulse and clip statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr     <= LFSR_INIT;
            r_data_p1  <= '0;
            r_vld_p1   <= 1'b0;
            r_clip_cnt <= '0;
        end else begin
            r_vld_p1 <= enable;
            if (enable) begin
                r_lfsr    <= {r_lfsr[14:0], w_fb};
                r_data_p1 <= sat_value(w_sum_p0);
                if (w_clip_p0 && (r_clip_cnt != 16'hFFFF))
                    r_clip_cnt <= r_clip_cnt + 16'd1;
            end
        end
    end

    assign data_out   = r_data_p1;
    assign out_valid  = r_vld_p1;
    assign clip_count = r_clip_cnt;

endmodule

// File: tb/tb_noise_injector.sv
// Randomized self-checking bench for noise_injector against an integer-arithmetic model.
module tb_noise_injector;

    localparam int DATA_W      = 24;
    localparam int NOISE_SHIFT = 4;
    localparam int MAXV        = (1 << (DATA_W-1)) - 1;
    localparam int MINV        = -(1 << (DATA_W-1));

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              noise_on = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [15:0]       clip_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [15:0]       m_lfsr;
    logic [DATA_W-1:0] m_out;
    logic              m_vld;
    int                m_clip;

    noise_injector #(.DATA_W(DATA_W), .NOISE_SHIFT(NOISE_SHIFT), .SEED(16'hACE1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .noise_on(noise_on),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int model_noise();
        return int'($signed(m_lfsr)) * (1 << NOISE_SHIFT);
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_out  = '0;
        m_vld  = 1'b0;
        m_clip = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".data"},  32'(data_out),   32'(m_out));
        chk({tag, ".vld"},   32'(out_valid),  32'(m_vld));
        chk({tag, ".clip"},  32'(clip_count), 32'(m_clip));
    endtask

    task automatic step(input string tag, input logic en, input logic non, input logic [DATA_W-1:0] din);
        int s;
        @(negedge clk);
        enable = en; noise_on = non; data_in = din;
        @(posedge clk);
        #1;
        if (en) begin
            s = int'($signed(din)) + (non ? model_noise() : 0);
            if (s > MAXV || s < MINV) begin
                m_out  = (s > MAXV) ? DATA_W'(MAXV) : DATA_W'(MINV);
                m_clip = (m_clip < 65535) ? m_clip + 1 : 65535;
            end else begin
                m_out = DATA_W'(s);
            end
            m_lfsr = lfsr_next(m_lfsr);
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        enable = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [DATA_W-1:0] hold_d;
        logic [15:0]       hold_c;
        model_reset();
        #12;
        chk("reset.data", 32'(data_out), 32'h0);
        chk("reset.vld",  32'(out_valid), 32'h0);
        chk("reset.clip", 32'(clip_count), 32'h0);
        reset_n = 1'b1;

        // first sample with default seed
        step("t1", 1'b1, 1'b1, '0);
        chk("t1.const", 32'(data_out), 32'h00FACE10);
        step("t1.idle", 1'b0, 1'b1, '0);
        chk("t1.pulse", 32'(out_valid), 32'h0);

        // positive clip with noise 0x059C30
        step("t2.pos", 1'b1, 1'b1, 24'h7FFFF0);
        chk("t2.pos.const", 32'(data_out), 32'h007FFFFF);
        chk("t2.pos.cnt", 32'(clip_count), 32'h1);

        do_reset();
        step("t2.neg", 1'b1, 1'b1, 24'h800000);
        chk("t2.neg.const", 32'(data_out), 32'h00800000);
        chk("t2.neg.cnt", 32'(clip_count), 32'h1);

        // passthrough ramp, then probe LFSR position via a noise-only sample
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step("t3.ramp", 1'b1, 1'b0, DATA_W'(i));
            chk("t3.ramp.val", 32'(data_out), 32'(i));
        end
        step("t3.lfsr", 1'b1, 1'b1, '0);

        // enable low for 20 cycles
        hold_d = data_out;
        hold_c = clip_count;
        for (int i = 0; i < 20; i++)
            step("t4.hold", 1'b0, i[0], DATA_W'($urandom));
        chk("t4.data", 32'(data_out), 32'(hold_d));
        chk("t4.clip", 32'(clip_count), 32'(hold_c));
        step("t4.lfsr", 1'b1, 1'b1, '0);

        // asynchronous reset between clock edges
        step("t5.pre", 1'b1, 1'b1, 24'h123456);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5.async.data", 32'(data_out), 32'h0);
        chk("t5.async.vld",  32'(out_valid), 32'h0);
        chk("t5.async.clip", 32'(clip_count), 32'h0);
        @(negedge clk);
        enable = 1'b0;
        reset_n = 1'b1;
        model_reset();
        step("t5.first", 1'b1, 1'b1, '0);
        chk("t5.first.const", 32'(data_out), 32'h00FACE10);

        // clip counter saturation
        do_reset();
        for (int i = 0; i < 70000; i++)
            step("t6.sat", 1'b1, 1'b1, (model_noise() > 0) ? 24'h7FFFFF : 24'h800000);
        chk("t6.sat.final", 32'(clip_count), 32'h0000FFFF);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            logic [DATA_W-1:0] d;
            case ($urandom_range(0, 3))
                0: d = 24'h7FFFFF - DATA_W'($urandom_range(0, 20000));
                1: d = 24'h800000 + DATA_W'($urandom_range(0, 20000));
                default: d = DATA_W'($urandom);
            endcase
            step("t6.rand", ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
